// File: rtl/adder_pipe_pkg.sv
// Shared constants and helpers for the pipelined add/sub unit.
// Saturation constants are consumed only when ADDER_PIPE_SAT_EN is defined.
package adder_pipe_pkg;

  localparam int ADDER_GROUP_DEF  = 4;
  localparam int ADDER_WIDTH_DEF  = 32;
  localparam int ADDER_STAGES_DEF = 2;
  localparam int ADDER_MAX_WIDTH  = 256;

  function automatic int slice_width(input int width, input int stages);
    if (stages > 0) begin
      return width / stages;
    end else begin
      return width;
    end
  endfunction

  // Largest positive two's-complement value of the given width: 0x7F..F.
  function automatic logic [ADDER_MAX_WIDTH-1:0] sat_max(input int width);
    logic [ADDER_MAX_WIDTH-1:0] v;
    v = {ADDER_MAX_WIDTH{1'b0}};
    for (int i = 0; i < width - 1; i++) begin
      v[i] = 1'b1;
    end
    return v;
  endfunction

  // Most negative two's-complement value of the given width: 0x80..0.
  function automatic logic [ADDER_MAX_WIDTH-1:0] sat_min(input int width);
    logic [ADDER_MAX_WIDTH-1:0] v;
    v = {ADDER_MAX_WIDTH{1'b0}};
    v[width-1] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/adder_cla_slice.sv
// One pipeline slice: W_S bits built from chained GROUP-bit carry-lookahead groups.
// c_msb is the carry into the slice MSB, used for signed-overflow detection.
module adder_cla_slice
  import adder_pipe_pkg::*;
#(
  parameter int W_S   = 16,
  parameter int GROUP = ADDER_GROUP_DEF
) (
  input  logic [W_S-1:0] a,
  input  logic [W_S-1:0] b,
  input  logic           cin,
  output logic [W_S-1:0] s,
  output logic           cout,
  output logic           c_msb
);

  localparam int NG = W_S / GROUP;

  logic [W_S-1:0] g_s;
  logic [W_S-1:0] p_s;
  logic [W_S-1:0] c_s;
  logic [NG:0]    gc_s;

  // Sum-of-products lookahead carry into bit n of a group (n = GROUP gives group carry-out).
  function automatic logic la_carry(
    input logic [GROUP-1:0] g,
    input logic [GROUP-1:0] p,
    input logic             ci,
    input int               n
  );
    logic res;
    logic term;
    res = ci;
    for (int j = 0; j < n; j++) begin
      res = res & p[j];
    end
    for (int j = 0; j < n; j++) begin
      term = g[j];
      for (int m = j + 1; m < n; m++) begin
        term = term & p[m];
      end
      res = res | term;
    end
    return res;
  endfunction

  assign g_s = a & b;
  assign p_s = a ^ b;

  // Bit carries inside each group and the group-to-group carry chain.
  always_comb begin
    c_s     = {W_S{1'b0}};
    gc_s    = {(NG+1){1'b0}};
    gc_s[0] = cin;
    for (int grp = 0; grp < NG; grp++) begin
      for (int i = 0; i < GROUP; i++) begin
        c_s[grp*GROUP+i] = la_carry(g_s[grp*GROUP +: GROUP], p_s[grp*GROUP +: GROUP],
                                    gc_s[grp], i);
      end
      gc_s[grp+1] = la_carry(g_s[grp*GROUP +: GROUP], p_s[grp*GROUP +: GROUP],
                             gc_s[grp], GROUP);
    end
  end

  assign s     = p_s ^ c_s;
  assign cout  = gc_s[NG];
  assign c_msb = c_s[W_S-1];

endmodule

// File: rtl/adder_pipe.sv
// Pipelined WIDTH-bit add/sub with valid/ready streaming and carry/overflow/zero flags.
// Optional saturation on signed overflow: define ADDER_PIPE_SAT_EN.
module adder_pipe
  import adder_pipe_pkg::*;
#(
  parameter int WIDTH  = ADDER_WIDTH_DEF,
  parameter int GROUP  = ADDER_GROUP_DEF,
  parameter int STAGES = ADDER_STAGES_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sub,
  input  logic             in_cin,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_s,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             out_zero,
  output logic             out_sat
);

  localparam int W_S = slice_width(WIDTH, STAGES);

  if (STAGES < 1 || (WIDTH % (STAGES * GROUP)) != 0) begin : g_cfg_err
    $error("adder_pipe: WIDTH must be a multiple of STAGES*GROUP and STAGES >= 1");
  end

`ifdef ADDER_PIPE_SAT_EN
  localparam logic [ADDER_MAX_WIDTH-1:0] SAT_MAX_FULL = sat_max(WIDTH);
  localparam logic [ADDER_MAX_WIDTH-1:0] SAT_MIN_FULL = sat_min(WIDTH);
  localparam logic [WIDTH-1:0]           SAT_MAX      = SAT_MAX_FULL[WIDTH-1:0];
  localparam logic [WIDTH-1:0]           SAT_MIN      = SAT_MIN_FULL[WIDTH-1:0];
`endif

  logic              adv_s;
  logic              cin_eff_s;
  logic              msb_carry_s;
  logic              ovf_s;
  logic              sat_s;
  logic [WIDTH-1:0]  b_eff_s;
  logic [WIDTH-1:0]  sum_s;
  logic [WIDTH-1:0]  res_s;
  logic [STAGES:0]   carry_s;
  logic [STAGES-1:0] vld_r;

  // Whole pipe advances together; a full output register blocks it until drained.
  assign adv_s      = out_ready | ~out_valid;
  assign in_ready   = adv_s;
  assign out_valid  = vld_r[STAGES-1];
  assign carry_s[0] = cin_eff_s;

  // Subtract is a + ~b + 1; the external carry-in is ignored in that mode.
  always_comb begin
    if (in_sub) begin
      b_eff_s   = ~in_b;
      cin_eff_s = 1'b1;
    end else begin
      b_eff_s   = in_b;
      cin_eff_s = in_cin;
    end
  end

  // Valid bit per stage; bubbles travel down the pipe like beats.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_r <= {STAGES{1'b0}};
    end else if (adv_s) begin
      vld_r[0] <= in_valid;
      for (int k = 1; k < STAGES; k++) begin
        vld_r[k] <= vld_r[k-1];
      end
    end
  end

  for (genvar j = 0; j < STAGES; j++) begin : g_slice
    logic [W_S-1:0] op_a_s;
    logic [W_S-1:0] op_b_s;
    logic [W_S-1:0] sum_slice_s;
    logic           cout_s;
    logic           cmsb_s;

    if (j == 0) begin : g_head
      assign op_a_s = in_a[W_S-1:0];
      assign op_b_s = b_eff_s[W_S-1:0];
    end else begin : g_skew
      logic [W_S-1:0] a_sr [j];
      logic [W_S-1:0] b_sr [j];

      // Upper-slice operands wait j cycles so they meet the carry from slice j-1.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < j; i++) begin
            a_sr[i] <= {W_S{1'b0}};
            b_sr[i] <= {W_S{1'b0}};
          end
        end else if (adv_s) begin
          a_sr[0] <= in_a[j*W_S +: W_S];
          b_sr[0] <= b_eff_s[j*W_S +: W_S];
          for (int i = 1; i < j; i++) begin
            a_sr[i] <= a_sr[i-1];
            b_sr[i] <= b_sr[i-1];
          end
        end
      end

      assign op_a_s = a_sr[j-1];
      assign op_b_s = b_sr[j-1];
    end

    adder_cla_slice #(
      .W_S   (W_S),
      .GROUP (GROUP)
    ) u_slice (
      .a     (op_a_s),
      .b     (op_b_s),
      .cin   (carry_s[j]),
      .s     (sum_slice_s),
      .cout  (cout_s),
      .c_msb (cmsb_s)
    );

    if (j < STAGES - 1) begin : g_mid
      localparam int D = STAGES - 1 - j;
      logic           c_r;
      logic [W_S-1:0] d_sr [D];
      logic           c_msb_unused;

      assign c_msb_unused = cmsb_s;

      // Registered inter-slice carry plus deskew of this slice's finished sum.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          c_r <= 1'b0;
          for (int i = 0; i < D; i++) begin
            d_sr[i] <= {W_S{1'b0}};
          end
        end else if (adv_s) begin
          c_r     <= cout_s;
          d_sr[0] <= sum_slice_s;
          for (int i = 1; i < D; i++) begin
            d_sr[i] <= d_sr[i-1];
          end
        end
      end

      assign carry_s[j+1]          = c_r;
      assign sum_s[j*W_S +: W_S]   = d_sr[D-1];
    end else begin : g_tail
      assign carry_s[j+1]          = cout_s;
      assign sum_s[j*W_S +: W_S]   = sum_slice_s;
      assign msb_carry_s           = cmsb_s;
    end
  end

  // Flags and optional saturation from the full-width raw result of the last slice.
  always_comb begin
    ovf_s = msb_carry_s ^ carry_s[STAGES];
`ifdef ADDER_PIPE_SAT_EN
    sat_s = ovf_s;
    if (ovf_s) begin
      if (sum_s[WIDTH-1]) begin
        res_s = SAT_MAX;
      end else begin
        res_s = SAT_MIN;
      end
    end else begin
      res_s = sum_s;
    end
`else
    sat_s = 1'b0;
    res_s = sum_s;
`endif
  end

  // Output register; holds its contents while the consumer stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_s    <= {WIDTH{1'b0}};
      out_cout <= 1'b0;
      out_ovf  <= 1'b0;
      out_zero <= 1'b0;
      out_sat  <= 1'b0;
    end else if (adv_s) begin
      out_s    <= res_s;
      out_cout <= carry_s[STAGES];
      out_ovf  <= ovf_s;
      out_zero <= (res_s == {WIDTH{1'b0}});
      out_sat  <= sat_s;
    end
  end

endmodule
